alu_op_arbiter: RTL and testbench

//   Shares one 8-bit ALU (a, b, 4-bit command, enable -> 16-bit out) between two requesters.

---
 rtl/alu_op_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_op_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_arbiter.sv
//==============================================================================
// Module      : alu_op_arbiter
// Description : Round-robin arbiter sharing one ALU between two valid/ready
//               requesters, with a single registered response port.
//               Optional divide-by-zero guard: define ALU_ARB_DIV_GUARD_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_op_arbiter #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 4
`ifdef ALU_ARB_DIV_GUARD_EN
    // Only meaningful when the guard exists, so it is only declared then.
    , parameter logic [CMD_W-1:0] DIV_CMD = 4'b0101
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    input  logic [CMD_W-1:0]      req0_cmd,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    input  logic [CMD_W-1:0]      req1_cmd,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [CMD_W-1:0]      alu_cmd,
    output logic                  alu_en,
    input  logic [2*DATA_W-1:0]   alu_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_rr_last;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_accept;
    logic                w_issue;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [CMD_W-1:0]    w_cmd;

    // Ready is masked while reset is asserted so no handshake is seen then.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_IDLE && reset_n) begin
            if (req0_valid && (!req1_valid || r_rr_last)) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_a        = w_gnt1 ? req1_a   : req0_a;
    assign w_b        = w_gnt1 ? req1_b   : req0_b;
    assign w_cmd      = w_gnt1 ? req1_cmd : req0_cmd;

`ifdef ALU_ARB_DIV_GUARD_EN
    assign w_issue = !((w_cmd == DIV_CMD) && (w_b == '0));
`else
    assign w_issue = 1'b1;
`endif

    // A guarded op enters CAPT with alu_en low; that is how CAPT tells the
    // two paths apart without an extra flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_rr_last <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cmd   <= '0;
            alu_en    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        rsp_id    <= w_gnt1;
                        r_rr_last <= w_gnt1;
                        if (w_issue) begin
                            alu_a   <= w_a;
                            alu_b   <= w_b;
                            alu_cmd <= w_cmd;
                            alu_en  <= 1'b1;
                            r_state <= S_EXEC;
                        end else begin
                            r_state <= S_CAPT;
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    rsp_data  <= alu_en ? alu_out : '1;
                    rsp_valid <= 1'b1;
                    alu_en    <= 1'b0;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_DIV_GUARD_EN
    logic r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_CAPT) begin
            r_err <= !alu_en;
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_op_arbiter.sv
//==============================================================================
// Module      : tb_alu_op_arbiter
// Description : Self-checking bench for alu_op_arbiter with a behavioural ALU
//               and a transaction-level arbitration model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_op_arbiter;

`ifdef ALU_ARB_DIV_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_cmd, req1_cmd;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_data;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_en;
    logic [15:0] alu_out;

    int checks = 0;
    int errors = 0;

    bit         pend [2];
    logic [7:0] op_a [2];
    logic [7:0] op_b [2];
    logic [3:0] op_c [2];
    bit         rr_m;

    alu_op_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .alu_en(alu_en), .alu_out(alu_out)
    );

    always #5 clock = ~clock;

    // Bench ALU: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 div, 6 xor.
    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] c);
        case (c)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return 16'(a & b);
            4'd4:    return 16'(a | b);
            4'd5:    return (b == 8'd0) ? 16'h0000 : 16'(a / b);
            4'd6:    return 16'(a ^ b);
            default: return 16'h0000;
        endcase
    endfunction

    always_comb alu_out = alu_en ? alu_ref(alu_a, alu_b, alu_cmd) : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Idle operand buses carry noise so capture outside the handshake shows up.
    task automatic drive_reqs();
        req0_valid = pend[0];
        req0_a     = pend[0] ? op_a[0] : 8'($urandom);
        req0_b     = pend[0] ? op_b[0] : 8'($urandom);
        req0_cmd   = pend[0] ? op_c[0] : 4'($urandom);
        req1_valid = pend[1];
        req1_a     = pend[1] ? op_a[1] : 8'($urandom);
        req1_b     = pend[1] ? op_b[1] : 8'($urandom);
        req1_cmd   = pend[1] ? op_c[1] : 4'($urandom);
    endtask

    task automatic arm(input int r, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] c);
        pend[r] = 1'b1;
        op_a[r] = a;
        op_b[r] = b;
        op_c[r] = c;
    endtask

    // One full transaction from IDLE; entered and left at posedge+1.
    task automatic run_one(input int bp);
        int          w;
        bit          dz;
        logic [15:0] ed;
        logic [7:0]  ca, cb;
        logic [3:0]  cc;
        drive_reqs();
        #1;
        w = (pend[0] && pend[1]) ? (rr_m ? 0 : 1) : (pend[0] ? 0 : 1);
        check("req0_ready_grant", req0_ready, 32'(w == 0));
        check("req1_ready_grant", req1_ready, 32'(w == 1));
        ca = op_a[w]; cb = op_b[w]; cc = op_c[w];
        dz = GUARD && cc == 4'd5 && cb == 8'd0;
        ed = dz ? 16'hFFFF : alu_ref(ca, cb, cc);
        @(posedge clock); #1;
        pend[w] = 1'b0;
        rr_m    = w[0];
        drive_reqs();
        check("alu_en_after_accept", alu_en, 32'(!dz));
        check("rsp_valid_early", rsp_valid, 0);
        check("ready_busy", {req1_ready, req0_ready}, 0);
        if (!dz) begin
            check("alu_a", alu_a, ca);
            check("alu_b", alu_b, cb);
            check("alu_cmd", alu_cmd, cc);
            @(posedge clock); #1;
            check("alu_en_capt", alu_en, 1);
            check("rsp_valid_capt", rsp_valid, 0);
        end
        @(posedge clock); #1;
        for (int k = 0; k <= bp; k++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_data", rsp_data, ed);
            check("rsp_id", rsp_id, w);
            check("rsp_err", rsp_err, 32'(dz));
            check("alu_en_resp", alu_en, 0);
            check("ready_resp", {req1_ready, req0_ready}, 0);
            if (k < bp) begin
                @(posedge clock); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        rr_m      = 1'b1;
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
        // Reset held with both requesters valid
        arm(0, 8'd1, 8'd2, 4'd0);
        arm(1, 8'd5, 8'd6, 4'd6);
        drive_reqs();
        repeat (3) @(posedge clock);
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu", {alu_a, alu_b, alu_cmd, alu_en}, 0);
        reset_n = 1'b1;
        run_one(0);             // tie after reset goes to req0
        run_one(0);             // drains req1

        // Single op 25+17
        arm(0, 8'd25, 8'd17, 4'd0);
        run_one(0);
        arm(1, 8'd200, 8'd200, 4'd2);
        run_one(0);             // full 16-bit product, also leaves rr_last=1

        // Contention: expected order 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) arm(0, 8'd4, 8'd3, 4'd2);
            if (!pend[1]) arm(1, 8'd20, 8'd10, 4'd1);
            run_one(0);
        end

        // Backpressure with the other requester waiting
        if (!pend[1]) arm(1, 8'd20, 8'd10, 4'd1);
        if (!pend[0]) arm(0, 8'd4, 8'd3, 4'd2);
        run_one(5);
        run_one(0);

        // Reset pulse while the op is in EXEC
        arm(0, 8'd3, 8'd4, 4'd0);
        drive_reqs();
        #1;
        check("mr_ready", req0_ready, 1);
        @(posedge clock); #1;
        pend[0] = 1'b0;
        drive_reqs();
        check("mr_exec_en", alu_en, 1);
        reset_n = 1'b0;
        #1;
        check("mr_alu_en", alu_en, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        #2;
        reset_n = 1'b1;
        rr_m    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("mr_no_rsp", {rsp_valid, alu_en}, 0);
        end

        // Divide by zero, then an ordinary divide
        arm(0, 8'd9, 8'd0, 4'd5);
        run_one(2);
        arm(1, 8'd9, 8'd3, 4'd5);
        run_one(0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0)
                    arm(r, 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom),
                        4'($urandom_range(0, 7)));
            end
            if (!pend[0] && !pend[1])
                arm(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    4'($urandom_range(0, 7)));
            run_one(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
